mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port SRAM memory controller between up to N requesters: the mini-EDSAC CPU, the initial-orders loader and the display scanner. Accepts per-port word requests, grants one at a time by round-robin or fixed priority, and drives the controller's one-cycle rd/wr strobe and mwait handshake. Returns read data and a one-cycle ack to the winner. Sits between the requesters and the memory controller; the controller and the arbiter share clock and reset.

## Interface
- N, 3, number of requester ports (2..4); port 0 = CPU, 1 = loader, 2 = scanner
- AW, 10, word address width
- DW, 16, data width
- RR, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
- TIMEOUT, 15, max cycles waiting for mwait to fall before abort
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- req  in  N  per-port request, held until ack
- we  in  N  per-port write enable (1 = write, 0 = read), stable while req
- addr  in  N*AW  packed per-port word addresses, port i at [i*AW +: AW]
- wdata  in  N*DW  packed per-port write data
- ack  out  N  one-cycle completion pulse to the granted port
- rdata  out  DW  read data, valid in the ack cycle
- err  out  1  one-cycle pulse with ack when a transaction timed out
- busy  out  1  high whenever state is not IDLE
- m_addr  out  AW  controller address
- m_d  out  DW  controller write data
- m_rd  out  1  controller read strobe
- m_wr  out  1  controller write strobe
- m_q  in  DW  controller read data
- m_wait  in  1  controller busy

## Operation
- States: IDLE, CMD, WAIT.
- IDLE: if any req bit and m_wait==0, pick winner g; register m_addr/m_d from port g, m_rd<=~we[g], m_wr<=we[g]; go CMD. Otherwise hold; strobes low.
- CMD: strobes high for exactly this cycle; at its end drop both strobes, clear timeout counter, go WAIT.
- WAIT: when m_wait==0, rdata<=m_q (reads only; writes leave rdata unchanged), ack[g]<=1, go IDLE; advance round-robin pointer to g+1 mod N. Counter increments each WAIT cycle with m_wait==1; on reaching TIMEOUT: ack[g]<=1, err<=1, rdata<=16'hDEAD, go IDLE.
- m_rd and m_wr never high together; never high outside CMD.
- Round-robin: search starts at pointer; pointer resets to 0. RR=0: pointer fixed at 0.
- Request dropped after grant: transaction still completes, ack still pulses.
- Requester must drop req (or present a new request) the cycle after ack; req still high in IDLE is a new request.
- Reset: state IDLE, ack=0, err=0, busy=0, rdata=0, m_addr=0, m_d=0, m_rd=0, m_wr=0, pointer=0. Reset mid-transaction abandons it with no ack.

## Timing
- Edge 0: IDLE samples req. Cycle 1: strobe high (CMD). Cycles 2–3: m_wait high (controller active). Cycle 4: m_wait low, m_q valid, sampled at edge 4. Cycle 5: ack and rdata visible; state IDLE.
- Latency: req-seen to ack = 5 cycles for reads and writes; back-to-back throughput 1 transaction per 5 cycles (next grant decided at edge 5, strobe in cycle 6).
- busy high in cycles 1–4.

## Structure
- Package mem_arb_pkg: AW/DW defaults, state enum (IDLE/CMD/WAIT), port index constants (PORT_CPU=0, PORT_LOAD=1, PORT_SCAN=2), timeout sentinel 16'hDEAD.
- Sub-module rr_pick: combinational N-way round-robin picker (req, pointer -> one-hot grant, index, any).

## Test plan
- Single read port 0, addr 10'h005, memory model returns 16'h1234 -> m_rd high cycle 1 only, ack[0] and rdata=16'h1234 in cycle 5.
- Write port 1, addr 10'h3FF, wdata 16'hBEEF -> m_wr one cycle with m_addr=10'h3FF, m_d=16'hBEEF; ack[1] cycle 5; readback by port 0 returns 16'hBEEF.
- All three ports requesting continuously, RR=1 -> grants 0,1,2,0,1,2, one ack every 5 cycles; RR=0 -> port 0 only while held.
- Model holds m_wait high forever -> after TIMEOUT cycles in WAIT, ack[g], err=1, rdata=16'hDEAD; next request served normally.
- reset asserted in WAIT -> next cycle all outputs 0, no ack; following request completes in 5 cycles.
- Port 2 drops req the cycle after grant -> transaction completes, ack[2] still pulses, no second strobe.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SRAM controller arbiter.
package mem_arb_pkg;

    localparam int unsigned AW_DEF    = 10;
    localparam int unsigned DW_DEF    = 16;

    localparam int unsigned PORT_CPU  = 0;
    localparam int unsigned PORT_LOAD = 1;
    localparam int unsigned PORT_SCAN = 2;

    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StWait
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational N-way round-robin picker: first requester at or after the pointer wins.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned N  = 3,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    localparam int unsigned SW = PW + 1;

    logic [N-1:0]  w_rot;
    logic [SW-1:0] w_sum;

    // Rotate so that bit 0 is the port the pointer names.
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        w_sum = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!o_any && w_rot[i]) begin
                o_any = 1'b1;
                w_sum = {1'b0, i_ptr} + SW'(i);
                if (w_sum >= SW'(N)) begin
                    w_sum = w_sum - SW'(N);
                end
                o_idx = w_sum[PW-1:0];
            end
        end
    end

    assign o_grant = N'(1) << o_idx;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates word requests from up to N requesters onto the single-port SRAM controller.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N       = 3,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned RR      = 1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    i_req,
    input  logic [N-1:0]    i_we,
    input  logic [N*AW-1:0] i_addr,
    input  logic [N*DW-1:0] i_wdata,
    output logic [N-1:0]    o_ack,
    output logic [DW-1:0]   o_rdata,
    output logic            o_err,
    output logic            o_busy,
    output logic [AW-1:0]   o_m_addr,
    output logic [DW-1:0]   o_m_d,
    output logic            o_m_rd,
    output logic            o_m_wr,
    input  logic [DW-1:0]   i_m_q,
    input  logic            i_m_wait
);

    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arb_state_t    r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_g;
    logic [N-1:0]  r_gnt;
    logic          r_wr_op;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_ack;
    logic          r_err;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_d;
    logic          r_m_rd;
    logic          r_m_wr;

    logic [N-1:0]  w_grant;
    logic [PW-1:0] w_idx;
    logic          w_any;
    logic [PW-1:0] w_ptr_next;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_ptr_next = (r_g == PW'(N - 1)) ? '0 : r_g + PW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= StIdle;
            r_ptr    <= '0;
            r_g      <= '0;
            r_gnt    <= '0;
            r_wr_op  <= 1'b0;
            r_cnt    <= '0;
            r_ack    <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_m_addr <= '0;
            r_m_d    <= '0;
            r_m_rd   <= 1'b0;
            r_m_wr   <= 1'b0;
        end else begin
            r_ack <= '0;
            r_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_any && !i_m_wait) begin
                        r_g      <= w_idx;
                        r_gnt    <= w_grant;
                        r_wr_op  <= i_we[w_idx];
                        r_m_addr <= i_addr[w_idx*AW +: AW];
                        r_m_d    <= i_wdata[w_idx*DW +: DW];
                        r_m_rd   <= ~i_we[w_idx];
                        r_m_wr   <= i_we[w_idx];
                        r_state  <= StCmd;
                    end
                end
                StCmd: begin
                    r_m_rd  <= 1'b0;
                    r_m_wr  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= StWait;
                end
                StWait: begin
                    if (!i_m_wait) begin
                        if (!r_wr_op) begin
                            r_rdata <= i_m_q;
                        end
                        r_ack   <= r_gnt;
                        r_ptr   <= (RR != 0) ? w_ptr_next : '0;
                        r_state <= StIdle;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        // Controller never released: abort with a recognisable sentinel.
                        r_ack   <= r_gnt;
                        r_err   <= 1'b1;
                        r_rdata <= DW'(TIMEOUT_DATA);
                        r_ptr   <= (RR != 0) ? w_ptr_next : '0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_ack    = r_ack;
    assign o_err    = r_err;
    assign o_rdata  = r_rdata;
    assign o_busy   = (r_state != StIdle);
    assign o_m_addr = r_m_addr;
    assign o_m_d    = r_m_d;
    assign o_m_rd   = r_m_rd;
    assign o_m_wr   = r_m_wr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small SRAM controller model.
module tb_mem_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req   = '0;
    logic [N-1:0]    we    = '0;
    logic [N*AW-1:0] addr  = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            busy;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_d;
    logic            m_rd;
    logic            m_wr;
    logic [DW-1:0]   m_q;
    logic            m_wait;

    logic [N-1:0]    f_req = '0;
    logic [N*AW-1:0] f_addr = {10'h003, 10'h002, 10'h001};
    logic [N-1:0]    f_ack;
    logic [DW-1:0]   f_rdata;
    logic            f_err;
    logic            f_busy;
    logic [AW-1:0]   f_m_addr;
    logic [DW-1:0]   f_m_d;
    logic            f_m_rd;
    logic            f_m_wr;
    logic            f_m_wait;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.N(N), .AW(AW), .DW(DW), .RR(1), .TIMEOUT(15)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .i_req    (req),
        .i_we     (we),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .o_ack    (ack),
        .o_rdata  (rdata),
        .o_err    (err),
        .o_busy   (busy),
        .o_m_addr (m_addr),
        .o_m_d    (m_d),
        .o_m_rd   (m_rd),
        .o_m_wr   (m_wr),
        .i_m_q    (m_q),
        .i_m_wait (m_wait)
    );

    mem_arbiter #(.N(N), .AW(AW), .DW(DW), .RR(0), .TIMEOUT(15)) u_dut_fixed (
        .clock    (clock),
        .reset    (reset),
        .i_req    (f_req),
        .i_we     ('0),
        .i_addr   (f_addr),
        .i_wdata  ('0),
        .o_ack    (f_ack),
        .o_rdata  (f_rdata),
        .o_err    (f_err),
        .o_busy   (f_busy),
        .o_m_addr (f_m_addr),
        .o_m_d    (f_m_d),
        .o_m_rd   (f_m_rd),
        .o_m_wr   (f_m_wr),
        .i_m_q    (16'h5A5A),
        .i_m_wait (f_m_wait)
    );

    // Controller model: busy for two cycles after a strobe, access done on the second.
    logic [DW-1:0] mem [0:1023];
    int unsigned   m_cnt;
    logic          m_hold;
    logic          m_stuck = 1'b0;
    logic          m_pwr;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pd;
    int unsigned   f_cnt;

    assign m_wait   = (m_cnt != 0) || m_hold;
    assign f_m_wait = (f_cnt != 0);

    always @(posedge clock) begin
        if (reset) begin
            m_cnt  <= 0;
            m_hold <= 1'b0;
        end else begin
            if (m_rd || m_wr) begin
                m_cnt   <= 2;
                m_hold  <= m_stuck;
                m_pwr   <= m_wr;
                m_paddr <= m_addr;
                m_pd    <= m_d;
            end else if (m_cnt == 1) begin
                m_cnt <= 0;
                if (m_pwr) mem[m_paddr] <= m_pd;
                else       m_q <= mem[m_paddr];
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end
            if (!m_stuck) m_hold <= 1'b0;
        end
    end

    always @(posedge clock) begin
        if (reset)                 f_cnt <= 0;
        else if (f_m_rd || f_m_wr) f_cnt <= 2;
        else if (f_cnt != 0)       f_cnt <= f_cnt - 1;
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({ack, err, busy, m_rd, m_wr} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0", {ack, err, busy, m_rd, m_wr});
        end
        n_checks++;
        if ({rdata, m_addr, m_d} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h m_addr=%h m_d=%h expected 0", rdata, m_addr, m_d);
        end
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        int c;
        logic [N-1:0] exp_ack;
        logic [DW-1:0] exp_d;
        addr = {10'h030, 10'h020, 10'h010};
        we   = '0;
        req  = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_ack = 3'b001 << (k % 3);
            exp_d   = 16'hA510 + 16'(16 * (k % 3));
            c = 0;
            do begin @(negedge clock); c++; end while (ack === '0 && c < 20);
            n_checks++;
            if (c != 5) begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d expected 5", k, c); end
            n_checks++;
            if (ack !== exp_ack) begin
                n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", k, ack, exp_ack);
            end
            n_checks++;
            if (rdata !== exp_d) begin
                n_fail++; $display("FAIL rr_rdata[%0d]: got %h expected %h", k, rdata, exp_d);
            end
        end
        req = '0;
    endtask

    task automatic test_read();
        addr = '0;
        addr[9:0] = 10'h005;
        we  = '0;
        req = 3'b001;
        @(negedge clock);
        n_checks++;
        if ({m_rd, m_wr, busy, m_addr} !== {3'b101, 10'h005}) begin
            n_fail++; $display("FAIL rd_cmd: got rd=%b wr=%b busy=%b addr=%h expected 1 0 1 005",
                               m_rd, m_wr, busy, m_addr);
        end
        @(negedge clock);
        n_checks++;
        if ({m_rd, m_wr, busy} !== 3'b001) begin
            n_fail++; $display("FAIL rd_strobe_drop: got %b expected 001", {m_rd, m_wr, busy});
        end
        repeat (2) @(negedge clock);
        n_checks++;
        if ({ack, busy} !== 4'b0001) begin
            n_fail++; $display("FAIL rd_cycle4: got ack=%b busy=%b expected 000 1", ack, busy);
        end
        @(negedge clock);
        n_checks++;
        if ({ack, err, busy, rdata} !== {3'b001, 2'b00, 16'h1234}) begin
            n_fail++; $display("FAIL rd_ack: got ack=%b err=%b busy=%b rdata=%h expected 001 0 0 1234",
                               ack, err, busy, rdata);
        end
        req = '0;
    endtask

    task automatic test_write();
        int c;
        addr = '0;
        addr[19:10] = 10'h3FF;
        wdata[31:16] = 16'hBEEF;
        we  = 3'b010;
        req = 3'b010;
        @(negedge clock);
        n_checks++;
        if ({m_rd, m_wr, m_addr, m_d} !== {2'b01, 10'h3FF, 16'hBEEF}) begin
            n_fail++; $display("FAIL wr_cmd: got rd=%b wr=%b addr=%h d=%h expected 0 1 3ff beef",
                               m_rd, m_wr, m_addr, m_d);
        end
        repeat (4) @(negedge clock);
        n_checks++;
        if ({ack, rdata} !== {3'b010, 16'h1234}) begin
            n_fail++; $display("FAIL wr_ack: got ack=%b rdata=%h expected 010 1234", ack, rdata);
        end
        we  = '0;
        addr[9:0] = 10'h3FF;
        req = 3'b001;
        c = 0;
        do begin @(negedge clock); c++; end while (ack === '0 && c < 20);
        n_checks++;
        if ({c[3:0], ack, rdata} !== {4'd5, 3'b001, 16'hBEEF}) begin
            n_fail++; $display("FAIL wr_readback: got c=%0d ack=%b rdata=%h expected 5 001 beef",
                               c, ack, rdata);
        end
        req = '0;
    endtask

    task automatic test_timeout();
        int c;
        addr = '0;
        addr[9:0] = 10'h005;
        m_stuck = 1'b1;
        req = 3'b001;
        c = 0;
        do begin @(negedge clock); c++; end while (ack === '0 && c < 40);
        n_checks++;
        if (c != 17) begin n_fail++; $display("FAIL to_latency: got %0d expected 17", c); end
        n_checks++;
        if ({ack, err, rdata} !== {3'b001, 1'b1, 16'hDEAD}) begin
            n_fail++; $display("FAIL to_abort: got ack=%b err=%b rdata=%h expected 001 1 dead",
                               ack, err, rdata);
        end
        req = '0;
        m_stuck = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({ack, err} !== 4'b0) begin
            n_fail++; $display("FAIL to_pulse: got ack=%b err=%b expected 000 0", ack, err);
        end
        req = 3'b001;
        c = 0;
        do begin @(negedge clock); c++; end while (ack === '0 && c < 20);
        n_checks++;
        if ({c[3:0], ack, err, rdata} !== {4'd5, 3'b001, 1'b0, 16'h1234}) begin
            n_fail++; $display("FAIL to_recover: got c=%0d ack=%b err=%b rdata=%h expected 5 001 0 1234",
                               c, ack, err, rdata);
        end
        req = '0;
    endtask

    task automatic test_drop_after_grant();
        int c;
        int n_strb;
        addr = {10'h020, 10'h000, 10'h000};
        req  = 3'b100;
        c = 0;
        n_strb = 0;
        do begin
            @(negedge clock); c++;
            if (m_rd || m_wr) n_strb++;
            if (c == 1) req = '0;
        end while (ack === '0 && c < 20);
        n_checks++;
        if ({c[3:0], ack, rdata} !== {4'd5, 3'b100, 16'hA520}) begin
            n_fail++; $display("FAIL drop_ack: got c=%0d ack=%b rdata=%h expected 5 100 a520",
                               c, ack, rdata);
        end
        repeat (3) begin
            @(negedge clock);
            if (m_rd || m_wr) n_strb++;
        end
        n_checks++;
        if (n_strb != 1) begin n_fail++; $display("FAIL drop_strobes: got %0d expected 1", n_strb); end
    endtask

    task automatic test_reset_mid();
        int c;
        logic [N-1:0] seen;
        addr = {10'h000, 10'h030, 10'h000};
        req  = 3'b010;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({ack, err, busy, m_rd, m_wr, rdata, m_addr, m_d} !== '0) begin
            n_fail++; $display("FAIL rstmid_out: got ack=%b err=%b busy=%b rd=%b wr=%b rdata=%h addr=%h d=%h expected 0",
                               ack, err, busy, m_rd, m_wr, rdata, m_addr, m_d);
        end
        reset = 1'b0;
        req   = '0;
        seen  = '0;
        repeat (4) begin @(negedge clock); seen = seen | ack; end
        n_checks++;
        if (seen !== '0) begin n_fail++; $display("FAIL rstmid_noack: got %b expected 000", seen); end
        req = 3'b010;
        c = 0;
        do begin @(negedge clock); c++; end while (ack === '0 && c < 20);
        n_checks++;
        if ({c[3:0], ack, rdata} !== {4'd5, 3'b010, 16'hA530}) begin
            n_fail++; $display("FAIL rstmid_next: got c=%0d ack=%b rdata=%h expected 5 010 a530",
                               c, ack, rdata);
        end
        req = '0;
    endtask

    task automatic test_fixed_priority();
        int c;
        f_req = 3'b111;
        @(negedge clock);
        n_checks++;
        if ({f_m_rd, f_m_wr, f_m_addr, f_m_d} !== {2'b10, 10'h001, 16'h0000}) begin
            n_fail++; $display("FAIL fp_cmd: got rd=%b wr=%b addr=%h d=%h expected 1 0 001 0000",
                               f_m_rd, f_m_wr, f_m_addr, f_m_d);
        end
        c = 1;
        for (int k = 0; k < 3; k++) begin
            while (f_ack === '0 && c < 20) begin @(negedge clock); c++; end
            n_checks++;
            if ({c[4:0], f_ack, f_rdata} !== {5'd5, 3'b001, 16'h5A5A}) begin
                n_fail++; $display("FAIL fp_ack[%0d]: got c=%0d ack=%b rdata=%h expected 5 001 5a5a",
                                   k, c, f_ack, f_rdata);
            end
            if (k == 2) f_req = 3'b110;
            @(negedge clock);
            c = 1;
        end
        while (f_ack === '0 && c < 20) begin @(negedge clock); c++; end
        n_checks++;
        if ({c[4:0], f_ack, f_err, f_busy} !== {5'd5, 3'b010, 2'b00}) begin
            n_fail++; $display("FAIL fp_next: got c=%0d ack=%b err=%b busy=%b expected 5 010 0 0",
                               c, f_ack, f_err, f_busy);
        end
        f_req = '0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= DW'(i) ^ 16'hA500;
        mem[5] <= 16'h1234;
        test_reset();
        test_round_robin();
        test_read();
        test_write();
        test_timeout();
        test_drop_after_grant();
        test_reset_mid();
        test_fixed_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
